multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 22 ++
 rtl/multiplier_if.sv | 33 +++
 rtl/mul_control.sv | 73 +++++++
 rtl/multiplier.sv | 69 ++++++
 tb/tb_multiplier.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/multiplier_pkg.sv
// ---------------------------------------------------------------
// multiplier_pkg : shared types and sizes for the multiplier
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package multiplier_pkg;

  localparam int WIDTH     = 8;
  localparam int ITERS     = 8;
  localparam int CHAIN_LEN = 32;
  localparam int CNT_W     = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/multiplier_if.sv
// ---------------------------------------------------------------
// multiplier_if : request, operand, result and scan signals
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface multiplier_if;
  import multiplier_pkg::*;

  logic                 req;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [WIDTH-1:0]     addend;
  logic                 test;
  logic                 sdi;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow;
  logic                 done;
  logic                 sdo;

  modport master (
    output req, multiplicand, multiplier, addend, test, sdi,
    input  product, overflow, done, sdo
  );

  modport slave (
    input  req, multiplicand, multiplier, addend, test, sdi,
    output product, overflow, done, sdo
  );

endinterface

`default_nettype wire

// File: rtl/mul_control.sv
// ---------------------------------------------------------------
// mul_control : IDLE/RUN/DONE sequencer and bit counter
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mul_control
  import multiplier_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             req,
  input  wire logic             test,
  output logic                  load,
  output logic                  add,
  output logic                  shift,
  output logic [CNT_W-1:0]      count,
  output logic                  done
);

  state_t           state, state_next;
  logic [CNT_W-1:0] count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Scan mode freezes the sequencer so a shift never disturbs a transaction
  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    add        = 1'b0;
    shift      = 1'b0;
    if (test) begin
      shift = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            load       = 1'b1;
            count_next = '0;
            state_next = RUN;
          end
        end
        RUN: begin
          add        = 1'b1;
          count_next = count + 1'b1;
          if (count == CNT_W'(ITERS - 1)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          if (!req) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: rtl/multiplier.sv
// ---------------------------------------------------------------
// multiplier : 8x8 shift-add multiply-accumulate with scan chain
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module multiplier
  import multiplier_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      rst,
  multiplier_if.slave    bus
);

  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 overflow;
  logic                 load, add, shift, done;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH-1:0]   acc_step;
  logic [CHAIN_LEN-1:0] chain_shifted;

  mul_control u_control (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.req),
    .test  (bus.test),
    .load  (load),
    .add   (add),
    .shift (shift),
    .count (count),
    .done  (done)
  );

  assign acc_step = mplier[count]
                  ? acc + ({{WIDTH{1'b0}}, mcand} << count)
                  : acc;

  // Chain runs SDI -> acc -> mcand -> mplier -> SDO, LSB to MSB within each
  assign chain_shifted = {mplier[WIDTH-2:0], mcand, acc, bus.sdi};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      overflow <= 1'b0;
    end else if (shift) begin
      {mplier, mcand, acc} <= chain_shifted;
    end else if (load) begin
      acc      <= {{WIDTH{1'b0}}, bus.addend};
      mcand    <= bus.multiplicand;
      mplier   <= bus.multiplier;
      overflow <= 1'b0;
    end else if (add) begin
      acc      <= acc_step;
      overflow <= |acc_step[2*WIDTH-1:WIDTH];
    end
  end

  assign bus.product  = acc;
  assign bus.overflow = overflow;
  assign bus.done     = done;
  assign bus.sdo      = mplier[WIDTH-1];

endmodule

`default_nettype wire

// File: tb/tb_multiplier.sv
// ---------------------------------------------------------------
// tb_multiplier : directed stimulus with queued expected results
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_multiplier;

  typedef struct {
    logic [15:0] product;
    logic        overflow;
    int          cap_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier_if bus();

  multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising Done is matched against the oldest outstanding request
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no result (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("product", 32'(bus.product), 32'(e.product));
          check("overflow", 32'(bus.overflow), 32'(e.overflow));
          check("latency", 32'(cyc - e.cap_cyc), 32'd8);
        end
      end
      prev = (bus.done === 1'b1);
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [15:0] ep, input logic eo, input bit expect_result);
    exp_t e;
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.addend       = c;
    bus.req          = 1'b1;
    @(posedge clk);
    #1;
    e.product  = ep;
    e.overflow = eo;
    e.cap_cyc  = cyc;
    if (expect_result) exp_q.push_back(e);
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    bus.addend       = ~c;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got done=0, expected done=1 within 20 cycles", name);
    end
  endtask

  task automatic release_and_check(input string name);
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    check(name, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] pat;
    logic [15:0] held;
    pat = 32'hA5A5_F00F;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.multiplicand = 8'hFF;
    bus.multiplier = 8'hFF;
    bus.addend = 8'hFF;
    bus.test = 1'b0;
    bus.sdi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sdo", 32'(bus.sdo), 32'd0);
    rst = 1'b0;

    // Basic, with Req held high through DONE
    issue(8'd13, 8'd7, 8'd5, 16'd96, 1'b0, 1'b1);
    wait_done("basic");
    held = bus.product;
    repeat (3) @(posedge clk);
    #1;
    check("done_held", 32'(bus.done), 32'd1);
    check("product_stable", 32'(bus.product), 32'(held));
    release_and_check("basic_release");

    issue(8'd255, 8'd255, 8'd255, 16'hFF00, 1'b1, 1'b1);
    wait_done("max");
    release_and_check("max_release");

    issue(8'd200, 8'd0, 8'd17, 16'd17, 1'b0, 1'b1);
    wait_done("zero");
    release_and_check("zero_release");

    // Early release: Req drops during RUN, Done must pulse for one cycle only
    issue(8'd13, 8'd7, 8'd5, 16'd96, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    wait_done("early");
    @(posedge clk);
    #1;
    check("early_one_cycle", 32'(bus.done), 32'd0);
    check("early_product_kept", 32'(bus.product), 32'd96);

    // Reset in RUN cycle 4 aborts; next request accepted straight away
    issue(8'd13, 8'd7, 8'd5, 16'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    issue(8'd3, 8'd3, 8'd1, 16'd10, 1'b0, 1'b1);
    wait_done("after_reset");
    release_and_check("after_reset_release");

    // Scan: Req held high must not start a transaction while Test=1
    @(negedge clk);
    bus.test = 1'b1;
    bus.req = 1'b1;
    for (int j = 0; j < 63; j++) begin
      if (j > 0) @(negedge clk);
      bus.sdi = (j < 32) ? pat[31 - j] : 1'b0;
      @(posedge clk);
      #1;
      if (j >= 31) check("scan_sdo", 32'(bus.sdo), 32'(pat[31 - (j - 31)]));
      if (j == 40) check("scan_done_held_low", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    bus.test = 1'b0;
    bus.req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("post_scan_done", 32'(bus.done), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
